dynamic_multi_bit_sreg: RTL and testbench



---
 rtl/dynamic_multi_bit_sreg.sv | 75 +++++++
 tb/tb_dynamic_multi_bit_sreg.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dynamic_multi_bit_sreg.sv
// Multi-bit shift register with a runtime-selected tap, fill tracking, synchronous flush
// and a rotate mode that recirculates the tapped word into stage 0.
module dynamic_multi_bit_sreg #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             ce_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] si_i,
    input  logic [AW-1:0]    addr_i,
    output logic [WIDTH-1:0] so_o,
    output logic             so_vld_o,
    output logic             full_o
);

    localparam int unsigned FW = $clog2(DEPTH + 1);
    localparam logic [FW-1:0] FillMax = FW'(DEPTH);
    localparam logic [AW:0] DepthExt = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] s_q [DEPTH];
    logic [WIDTH-1:0] s_d [DEPTH];
    logic [FW-1:0]    fill_q, fill_d;
    logic             addr_ok;
    logic [WIDTH-1:0] tap;

    // addr can exceed DEPTH-1 only when DEPTH is not a power of two
    assign addr_ok = ({1'b0, addr_i} < DepthExt);
    assign tap     = addr_ok ? s_q[addr_i] : '0;

    assign so_o     = tap;
    assign so_vld_o = addr_ok && (fill_q > FW'(addr_i));
    assign full_o   = (fill_q == FillMax);

    always_comb begin
        s_d    = s_q;
        fill_d = fill_q;
        if (clr_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                s_d[k] = '0;
            end
            fill_d = '0;
        end else if (ce_i) begin
            if (!mode_i) begin
                for (int k = 1; k < DEPTH; k++) begin
                    s_d[k] = s_q[k-1];
                end
                s_d[0] = si_i;
                fill_d = (fill_q == FillMax) ? fill_q : fill_q + FW'(1);
            end else if (addr_ok) begin
                // tap is sampled from the pre-shift contents
                for (int k = 1; k < DEPTH; k++) begin
                    s_d[k] = s_q[k-1];
                end
                s_d[0] = tap;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                s_q[k] <= '0;
            end
            fill_q <= '0;
        end else begin
            s_q    <= s_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: tb/tb_dynamic_multi_bit_sreg.sv
// Bench for dynamic_multi_bit_sreg: DEPTH=16 and DEPTH=12 instances share stimulus and are
// compared against an array-based model plus directed vectors.
module tb_dynamic_multi_bit_sreg;

    logic       clk = 1'b0;
    logic       rst_n, clr, ce, mode;
    logic [3:0] si, addr;
    logic [3:0] so_a, so_b;
    logic       vld_a, vld_b, full_a, full_b;

    int checks = 0;
    int errors = 0;

    int unsigned mq [2][16];
    int          mf [2];
    int          dep [2];

    typedef struct {
        logic       clr, ce, mode;
        logic [3:0] si, addr;
        logic [3:0] so;
        logic       vld, full;
    } vec_t;
    vec_t tbl [8];

    dynamic_multi_bit_sreg #(.WIDTH(4), .DEPTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .ce_i(ce), .mode_i(mode), .si_i(si),
        .addr_i(addr), .so_o(so_a), .so_vld_o(vld_a), .full_o(full_a)
    );

    dynamic_multi_bit_sreg #(.WIDTH(4), .DEPTH(12)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .ce_i(ce), .mode_i(mode), .si_i(si),
        .addr_i(addr), .so_o(so_b), .so_vld_o(vld_b), .full_o(full_b)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 16; k++) mq[d][k] = 0;
            mf[d] = 0;
        end
    endtask

    task automatic model_edge();
        int unsigned w;
        for (int d = 0; d < 2; d++) begin
            if (clr) begin
                for (int k = 0; k < 16; k++) mq[d][k] = 0;
                mf[d] = 0;
            end else if (ce && (!mode || int'(addr) < dep[d])) begin
                w = mode ? mq[d][addr] : int'(si);
                for (int k = dep[d] - 1; k > 0; k--) mq[d][k] = mq[d][k-1];
                mq[d][0] = w;
                if (!mode && mf[d] < dep[d]) mf[d]++;
            end
        end
    endtask

    task automatic check_model(input string nm);
        int e_so, e_v, e_f;
        for (int d = 0; d < 2; d++) begin
            e_so = (int'(addr) < dep[d]) ? int'(mq[d][addr]) : 0;
            e_v  = (int'(addr) < dep[d] && mf[d] > int'(addr)) ? 1 : 0;
            e_f  = (mf[d] == dep[d]) ? 1 : 0;
            chk($sformatf("%s_d%0d_so", nm, dep[d]), (d == 0) ? int'(so_a) : int'(so_b), e_so);
            chk($sformatf("%s_d%0d_vld", nm, dep[d]), (d == 0) ? int'(vld_a) : int'(vld_b), e_v);
            chk($sformatf("%s_d%0d_full", nm, dep[d]), (d == 0) ? int'(full_a) : int'(full_b), e_f);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_prev, exp_act;
        dep[0] = 16;
        dep[1] = 12;
        rst_n = 1'b0; clr = 1'b0; ce = 1'b0; mode = 1'b0; si = '0; addr = '0;
        model_reset();

        //              clr ce mode si addr so vld full
        tbl[0] = '{1'b0, 1'b1, 1'b0, 4'd1, 4'd3, 4'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 4'd2, 4'd3, 4'd0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 4'd3, 4'd3, 4'd0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 4'd4, 4'd3, 4'd1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 4'd5, 4'd3, 4'd2, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 4'd9, 4'd3, 4'd2, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 4'd9, 4'd0, 4'd5, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 4'd9, 4'd0, 4'd0, 1'b0, 1'b0};

        #12;
        chk("reset_so", int'(so_a), 0);
        chk("reset_vld", int'(vld_a), 0);
        chk("reset_full", int'(full_a), 0);
        check_model("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            clr = tbl[i].clr; ce = tbl[i].ce; mode = tbl[i].mode;
            si = tbl[i].si; addr = tbl[i].addr;
            step();
            chk($sformatf("tbl%0d_so", i), int'(so_a), int'(tbl[i].so));
            chk($sformatf("tbl%0d_vld", i), int'(vld_a), int'(tbl[i].vld));
            chk($sformatf("tbl%0d_full", i), int'(full_a), int'(tbl[i].full));
            check_model($sformatf("tbl%0d", i));
        end
        clr = 1'b0;

        // Gapped ce: three idle clocks then one active clock, addr=2
        addr = 4'd2;
        exp_prev = 0;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 3; i++) begin
                ce = 1'b0;
                si = 4'd15;
                step();
                chk($sformatf("gap_idle%0d_%0d", p, i), int'(so_a), exp_prev);
            end
            ce = 1'b1;
            si = (p == 0) ? 4'd7 : 4'(10 + p);
            step();
            exp_act = (p == 2) ? 7 : (p == 3) ? 11 : 0;
            chk($sformatf("gap_act%0d", p), int'(so_a), exp_act);
            check_model($sformatf("gap%0d", p));
            exp_prev = exp_act;
        end

        // Fill saturation, then flush with ce asserted
        for (int k = 1; k <= 20; k++) begin
            ce = 1'b1; mode = 1'b0; si = 4'(k); addr = 4'd0;
            step();
        end
        ce = 1'b0;
        chk("sat_full", int'(full_a), 1);
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            #1;
            chk($sformatf("sat_so%0d", a), int'(so_a), (20 - a) % 16);
            chk($sformatf("sat_vld%0d", a), int'(vld_a), 1);
        end
        @(posedge clk);
        #1;
        clr = 1'b1; ce = 1'b1; si = 4'd6; addr = 4'd15;
        step();
        clr = 1'b0; ce = 1'b0;
        chk("flush_so15", int'(so_a), 0);
        chk("flush_vld15", int'(vld_a), 0);
        chk("flush_full", int'(full_a), 0);
        check_model("flush");

        // Rotate with addr=3 after preloading 10,11,12,13
        for (int k = 0; k < 4; k++) begin
            ce = 1'b1; mode = 1'b0; si = 4'(10 + k); addr = 4'd3;
            step();
        end
        chk("rot_pre", int'(so_a), 10);
        mode = 1'b1; si = 4'd15;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("rot%0d", k), int'(so_a), (k == 4) ? 10 : 10 + k);
            chk($sformatf("rot%0d_vld", k), int'(vld_a), 1);
            check_model($sformatf("rot%0d", k));
        end
        ce = 1'b0; mode = 1'b0; addr = 4'd4;
        #1;
        chk("rot_fill_vld4", int'(vld_a), 0);

        // Dynamic tap sweep: stages loaded with 1..16 (truncated to 4 bits)
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            ce = 1'b1; si = 4'(k);
            step();
        end
        ce = 1'b0;
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            #1;
            chk($sformatf("tap%0d", a), int'(so_a), (16 - a) % 16);
            check_model($sformatf("tap%0d", a));
        end
        @(posedge clk);
        #1;

        // Asynchronous reset between edges during shifting
        addr = 4'd0; ce = 1'b1; si = 4'd5;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_so", int'(so_a), 0);
        chk("arst_vld", int'(vld_a), 0);
        chk("arst_full", int'(full_a), 0);
        check_model("arst");
        #2;
        rst_n = 1'b1;
        si = 4'd9;
        step();
        chk("arst_first_so", int'(so_a), 9);
        chk("arst_first_vld", int'(vld_a), 1);
        addr = 4'd1;
        #1;
        chk("arst_first_vld1", int'(vld_a), 0);
        check_model("arst_first");

        // DEPTH=12: out-of-range tap reads and rotate
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            ce = 1'b1; mode = 1'b0; si = 4'(k); addr = 4'd0;
            step();
        end
        ce = 1'b0; addr = 4'd13;
        #1;
        chk("d12_oor_so", int'(so_b), 0);
        chk("d12_oor_vld", int'(vld_b), 0);
        chk("d12_full", int'(full_b), 1);
        ce = 1'b1; mode = 1'b1;
        step();
        ce = 1'b0; mode = 1'b0;
        for (int a = 0; a < 12; a++) begin
            addr = 4'(a);
            #1;
            chk($sformatf("d12_hold%0d", a), int'(so_b), 12 - a);
        end
        chk("d12_hold_full", int'(full_b), 1);
        @(posedge clk);
        #1;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            clr  = ($urandom_range(0, 19) == 0);
            ce   = ($urandom_range(0, 3) != 0);
            mode = ($urandom_range(0, 2) == 0);
            si   = 4'($urandom);
            addr = 4'($urandom);
            step();
            check_model("rand");
            addr = 4'($urandom);
            #1;
            check_model("rand_addr");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
